regfile_dump_reader: RTL and testbench

//  Debug-side reader for the 32-entry CPU register file. On a start pulse it sweeps the

---
 rtl/regfile_dump_reader_pkg.sv | 17 +
 rtl/regfile_dump_reader_byte_shift_out.sv | 27 ++
 rtl/regfile_dump_reader.sv | 133 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - state encodings and defaults for the register file dump reader
package regfile_dump_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEL  = 3'd2,
        ST_CAP  = 3'd3,
        ST_IDX  = 3'd4,
        ST_DATA = 3'd5,
        ST_DONE = 3'd6
    } dump_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         SEL_W             = 5;

endpackage

// File: rtl/regfile_dump_reader_byte_shift_out.sv
// rtl/regfile_dump_reader_byte_shift_out.sv - word shift register emitting its MSB byte first
module regfile_dump_reader_byte_shift_out #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             shift,
    output logic [7:0]       byte_out
);

    logic [WIDTH-1:0] word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            word <= '0;
        end else if (load) begin
            word <= load_word;
        end else if (shift) begin
            word <= word << 8;
        end
    end

    assign byte_out = word[WIDTH-1 -: 8];

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - sweeps the register file debug port and streams a framed byte dump
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         NUM_REGS  = 32,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [SEL_W-1:0] dbg_sel,
    input  logic [WIDTH-1:0] dbg_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

    localparam int               NBYTES    = WIDTH / 8;
    localparam int               BCW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0]   LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REGS - 1);

    dump_state_t      state;
    dump_state_t      next_state;
    logic [SEL_W-1:0] idx;
    logic [BCW-1:0]   byte_cnt;
    logic             word_load;
    logic             word_shift;
    logic [7:0]       word_byte;

    regfile_dump_reader_byte_shift_out #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (word_load),
        .load_word (dbg_data),
        .shift     (word_shift),
        .byte_out  (word_byte)
    );

    always_comb begin
        next_state = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b1;
        done       = 1'b0;
        word_load  = 1'b0;
        word_shift = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) next_state = ST_SYNC;
            end
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) next_state = ST_SEL;
            end
            ST_SEL: begin
                next_state = ST_CAP;
            end
            ST_CAP: begin
                word_load  = 1'b1;
                next_state = ST_IDX;
            end
            ST_IDX: begin
                tx_valid = 1'b1;
                tx_data  = {3'b000, idx};
                if (tx_ready) next_state = ST_DATA;
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = word_byte;
                if (tx_ready) begin
                    word_shift = 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        next_state = (idx == LAST_IDX) ? ST_DONE : ST_SEL;
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = ST_IDLE;
            end
        endcase
    end

    // dbg_sel is registered in SEL so the combinational read data is settled by CAP
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            byte_cnt <= '0;
            dbg_sel  <= '0;
        end else begin
            state <= next_state;
            unique case (state)
                ST_IDLE: begin
                    idx      <= '0;
                    byte_cnt <= '0;
                end
                ST_SEL: begin
                    dbg_sel <= idx;
                end
                ST_CAP: begin
                    byte_cnt <= '0;
                end
                ST_DATA: begin
                    if (tx_ready) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            if (idx != LAST_IDX) idx <= idx + 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed bench for regfile_dump_reader
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  exp_b [161];
    logic [7:0]  rx [161];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dbg_data = (dbg_sel == 5'd0) ? 32'h0 : regs[dbg_sel];

    regfile_dump_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic build_exp();
        logic [31:0] w;
        int          base;
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 32; i++) begin
            base = 1 + 5 * i;
            w = (i == 0) ? 32'h0 : regs[i];
            exp_b[base]     = {3'b000, 5'(i)};
            exp_b[base + 1] = w[31:24];
            exp_b[base + 2] = w[23:16];
            exp_b[base + 3] = w[15:8];
            exp_b[base + 4] = w[7:0];
        end
    endtask

    // Runs one frame from a start pulse; optional start poke, live write, or abort by byte count.
    task automatic run_frame(input int ready_pct, input int poke_at, input int live_at,
                             input int abort_at, output int nbytes, output int ndone,
                             output int done_cycle);
        int         n;
        int         cyc;
        logic       stalled;
        logic [7:0] stall_data;
        logic       poked;
        n = 0; ndone = 0; done_cycle = 0; stalled = 1'b0; stall_data = 8'h00; poked = 1'b0;
        build_exp();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_valid", 32'(tx_valid), 32'd1);
        check("start_data", 32'(tx_data), 32'hA5);
        check("start_busy", 32'(busy), 32'd1);
        for (cyc = 1; cyc < 3000; cyc++) begin
            if (poked) begin
                start = 1'b0;
                poked = 1'b0;
            end
            tx_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (abort_at > 0 && n >= abort_at && tx_valid) begin
                tx_ready = 1'b0;
                reset = 1'b0;
                @(negedge clk);
                check("abort_valid", 32'(tx_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                reset = 1'b1;
                break;
            end
            if (stalled) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (done) begin
                ndone++;
                done_cycle = cyc;
            end
            if (tx_valid && tx_ready) begin
                if (n < 161) begin
                    check($sformatf("byte%0d", n), 32'(tx_data), 32'(exp_b[n]));
                    rx[n] = tx_data;
                end else begin
                    check("extra_byte", n, 161);
                end
                n++;
                if (n == live_at) begin
                    regs[5] = 32'hCAFEF00D;
                    build_exp();
                end
                if (n == poke_at) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
            end
            stalled = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (ndone > 0 && cyc >= done_cycle + 10) break;
            @(negedge clk);
        end
        if (cyc >= 3000) check("timeout", 32'd0, 32'd1);
        start = 1'b0;
        nbytes = n;
    endtask

    int nb;
    int nd;
    int dc;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}} ^ 32'h5A00_0000;
        regs[1]  = 32'h11223344;
        regs[31] = 32'hDEADBEEF;

        // reset held with start asserted
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sel", 32'(dbg_sel), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // full dump, always ready
        run_frame(100, 0, 0, 0, nb, nd, dc);
        check("t2_bytes", nb, 161);
        check("t2_done", nd, 1);
        check("t2_done_cycle", dc, 226);
        check("t2_r1", {rx[7], rx[8], rx[9], rx[10]}, 32'h11223344);
        check("t2_r0", {rx[2], rx[3], rx[4], rx[5]}, 32'h0);
        check("t2_r31_idx", 32'(rx[156]), 32'h1F);
        check("t2_r31", {rx[157], rx[158], rx[159], rx[160]}, 32'hDEADBEEF);
        check("t2_sel_hold", 32'(dbg_sel), 32'd31);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // random backpressure
        run_frame(50, 0, 0, 0, nb, nd, dc);
        check("t3_bytes", nb, 161);
        check("t3_done", nd, 1);
        check("t3_r31", {rx[157], rx[158], rx[159], rx[160]}, 32'hDEADBEEF);

        // start while busy is ignored
        run_frame(100, 50, 0, 0, nb, nd, dc);
        check("t4_bytes", nb, 161);
        check("t4_done", nd, 1);
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_valid_after", 32'(tx_valid), 32'd0);

        // reset mid-frame, then a clean frame
        run_frame(100, 0, 0, 40, nb, nd, dc);
        check("t5_abort_bytes", nb, 40);
        check("t5_abort_done", nd, 0);
        run_frame(100, 0, 0, 0, nb, nd, dc);
        check("t5_bytes", nb, 161);
        check("t5_first", 32'(rx[0]), 32'hA5);
        check("t5_done", nd, 1);

        // live write to r5 before it is captured
        run_frame(100, 0, 10, 0, nb, nd, dc);
        check("t6_bytes", nb, 161);
        check("t6_r5_idx", 32'(rx[26]), 32'h05);
        check("t6_r5", {rx[27], rx[28], rx[29], rx[30]}, 32'hCAFEF00D);
        check("t6_done", nd, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
